run_length_tx: RTL and testbench

RUN_LENGTH_TX -- requirements
Module: run_length_tx

---
 rtl/run_length_tx.sv | 103 ++++++++++
 tb/tb_run_length_tx.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_length_tx.sv
// Run-length waveform generator: queued {level, len} commands are played
// back-to-back on signal_out, each held for max(len, 1) clock cycles.
module run_length_tx #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     cmd_level_in,
  input  logic [LEN_W-1:0]         cmd_len_in,
  input  logic                     cmd_valid_in,
  output logic                     cmd_ready_out,
  output logic                     signal_out,
  output logic                     busy_out,
  output logic                     underrun_out,
  output logic [$clog2(DEPTH):0]   fifo_count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [LEN_W-1:0] remain;
  logic             level_mem [DEPTH];
  logic [LEN_W-1:0] len_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             head_level;
  logic [LEN_W-1:0] head_len;
  logic [LEN_W-1:0] head_remain;

  // Handshake: a command transfers on a rising edge where cmd_valid_in and
  // cmd_ready_out are both 1. Ready looks only at the registered count and
  // reset, so a pop on the same edge never frees a slot early.
  assign cmd_ready_out = (fifo_count_out < FULL_COUNT) && rst_in;
  assign push          = cmd_valid_in && cmd_ready_out;
  assign fifo_empty    = (fifo_count_out == '0);
  assign pop           = !fifo_empty && ((state == IDLE) || (remain == '0));
  assign head_level    = level_mem[rd_ptr];
  assign head_len      = len_mem[rd_ptr];
  // A zero-length command still occupies one cycle.
  assign head_remain   = (head_len == '0) ? '0 : head_len - LEN_W'(1);
  assign busy_out      = (state == RUN);

  always_ff @(posedge clk_in) begin
    if (push) begin
      level_mem[wr_ptr] <= cmd_level_in;
      len_mem[wr_ptr]   <= cmd_len_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count_out <= '0;
      state          <= IDLE;
      remain         <= '0;
      signal_out     <= 1'b0;
      underrun_out   <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   fifo_count_out <= fifo_count_out + CNT_W'(1);
        2'b01:   fifo_count_out <= fifo_count_out - CNT_W'(1);
        default: ;
      endcase

      underrun_out <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            signal_out <= head_level;
            remain     <= head_remain;
            state      <= RUN;
          end
        end
        RUN: begin
          if (remain != '0) begin
            remain <= remain - LEN_W'(1);
          end else if (!fifo_empty) begin
            signal_out <= head_level;
            remain     <= head_remain;
          end else begin
            state        <= IDLE;
            underrun_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_length_tx.sv
// Bench for run_length_tx: directed scenarios plus random traffic, each cycle
// checked against a timeline model of run start/end edges.
module tb_run_length_tx;

  localparam int DEPTH = 4;
  localparam int LEN_W = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             cmd_level_in;
  logic [LEN_W-1:0] cmd_len_in;
  logic             cmd_valid_in;
  logic             cmd_ready_out;
  logic             signal_out;
  logic             busy_out;
  logic             underrun_out;
  logic [CNT_W-1:0] fifo_count_out;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  // One entry per accepted command: accept edge, first and one-past-last
  // edge of its run, and its level.
  typedef struct {
    int   a;
    int   s;
    int   e;
    logic lvl;
  } run_t;
  run_t runs[$];

  run_length_tx #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .cmd_level_in   (cmd_level_in),
    .cmd_len_in     (cmd_len_in),
    .cmd_valid_in   (cmd_valid_in),
    .cmd_ready_out  (cmd_ready_out),
    .signal_out     (signal_out),
    .busy_out       (busy_out),
    .underrun_out   (underrun_out),
    .fifo_count_out (fifo_count_out)
  );

  // Clock and edge counter: after edge n, cyc == n.
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic int model_count(int n);
    int c = 0;
    foreach (runs[k]) begin
      if (runs[k].a <= n) c++;
      if (runs[k].s <= n) c--;
    end
    return c;
  endfunction

  function automatic logic exp_sig(int n);
    logic l = 1'b0;
    foreach (runs[k]) if (runs[k].s <= n) l = runs[k].lvl;
    return l;
  endfunction

  function automatic logic exp_busy(int n);
    foreach (runs[k]) if (runs[k].s <= n && n < runs[k].e) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_under(int n);
    foreach (runs[k]) begin
      if (runs[k].e == n) begin
        if (k == runs.size() - 1) return 1'b1;
        if (runs[k + 1].s > n) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // ---------------- driver ----------------
  // Called just after edge n; applies inputs for edge n+1, samples ready,
  // updates the model, and returns just after edge n+1.
  task automatic drive(input logic v, input logic lv, input int ln, input logic rv,
                       output logic rdy_obs, output logic rdy_exp, output logic acc);
    run_t r;
    int   eff;
    cmd_valid_in = v;
    cmd_level_in = lv;
    cmd_len_in   = LEN_W'(ln);
    rst_in       = rv;
    #1;
    rdy_obs = cmd_ready_out;
    rdy_exp = rv && (model_count(cyc) < DEPTH);
    acc     = v && rdy_exp;
    if (!rv) begin
      runs.delete();
    end else if (acc) begin
      eff   = (ln == 0) ? 1 : ln;
      r.a   = cyc + 1;
      r.s   = r.a + 1;
      if (runs.size() > 0 && runs[$].e > r.s) r.s = runs[$].e;
      r.e   = r.s + eff;
      r.lvl = lv;
      runs.push_back(r);
    end
    @(posedge clk_in);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic ro, re, ac;
    logic [CNT_W+2:0] got, want;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5, 1'b0, ro, re, ac);
      tests++;
      if (ro !== 1'b0 || ac) begin
        fails++; $display("FAIL reset_ready cyc=%0d got %b expected 0", cyc, ro);
      end
      got  = {signal_out, busy_out, underrun_out, fifo_count_out};
      want = '0;
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL reset_outputs cyc=%0d {sig,busy,und,cnt} got %b expected %b", cyc, got, want);
      end
    end
  endtask

  task automatic test_single();
    logic ro, re, ac;
    logic [CNT_W+2:0] got, want;
    logic [5:0] sig_tr = '0, busy_tr = '0, und_tr = '0;
    for (int i = 0; i < 7; i++) begin
      drive(i == 0, 1'b1, 3, 1'b1, ro, re, ac);
      tests++;
      if (ro !== re) begin
        fails++; $display("FAIL single_ready cyc=%0d got %b expected %b", cyc, ro, re);
      end
      got  = {signal_out, busy_out, underrun_out, fifo_count_out};
      want = {exp_sig(cyc), exp_busy(cyc), exp_under(cyc), CNT_W'(model_count(cyc))};
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL single_outputs cyc=%0d {sig,busy,und,cnt} got %b expected %b", cyc, got, want);
      end
      if (i > 0) begin
        sig_tr  = {sig_tr[4:0], signal_out};
        busy_tr = {busy_tr[4:0], busy_out};
        und_tr  = {und_tr[4:0], underrun_out};
      end
    end
    tests++;
    if ({sig_tr, busy_tr, und_tr} !== {6'b111111, 6'b111000, 6'b000100}) begin
      fails++; $display("FAIL single_trace got sig=%b busy=%b und=%b expected 111111/111000/000100",
                        sig_tr, busy_tr, und_tr);
    end
  endtask

  task automatic test_back_to_back();
    logic ro, re, ac;
    logic [CNT_W+2:0] got, want;
    logic [7:0] sig_tr = '0, busy_tr = '0, und_tr = '0;
    int lens [3] = '{2, 3, 1};
    logic lvls [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      drive(i < 3, (i < 3) ? lvls[i] : 1'b0, (i < 3) ? lens[i] : 0, 1'b1, ro, re, ac);
      tests++;
      if (ro !== re) begin
        fails++; $display("FAIL b2b_ready cyc=%0d got %b expected %b", cyc, ro, re);
      end
      got  = {signal_out, busy_out, underrun_out, fifo_count_out};
      want = {exp_sig(cyc), exp_busy(cyc), exp_under(cyc), CNT_W'(model_count(cyc))};
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL b2b_outputs cyc=%0d {sig,busy,und,cnt} got %b expected %b", cyc, got, want);
      end
      if (i > 0) begin
        sig_tr  = {sig_tr[6:0], signal_out};
        busy_tr = {busy_tr[6:0], busy_out};
        und_tr  = {und_tr[6:0], underrun_out};
      end
    end
    tests++;
    if ({sig_tr, busy_tr, und_tr} !== {8'b11000111, 8'b11111100, 8'b00000010}) begin
      fails++; $display("FAIL b2b_trace got sig=%b busy=%b und=%b expected 11000111/11111100/00000010",
                        sig_tr, busy_tr, und_tr);
    end
  endtask

  task automatic test_len0_merge();
    logic ro, re, ac;
    logic [CNT_W+2:0] got, want;
    logic [4:0] sig_tr = '0, busy_tr = '0, und_tr = '0;
    for (int i = 0; i < 6; i++) begin
      drive(i < 2, 1'b0, (i == 1) ? 2 : 0, 1'b1, ro, re, ac);
      tests++;
      if (ro !== re) begin
        fails++; $display("FAIL len0_ready cyc=%0d got %b expected %b", cyc, ro, re);
      end
      got  = {signal_out, busy_out, underrun_out, fifo_count_out};
      want = {exp_sig(cyc), exp_busy(cyc), exp_under(cyc), CNT_W'(model_count(cyc))};
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL len0_outputs cyc=%0d {sig,busy,und,cnt} got %b expected %b", cyc, got, want);
      end
      if (i > 0) begin
        sig_tr  = {sig_tr[3:0], signal_out};
        busy_tr = {busy_tr[3:0], busy_out};
        und_tr  = {und_tr[3:0], underrun_out};
      end
    end
    tests++;
    if ({sig_tr, busy_tr, und_tr} !== {5'b00000, 5'b11100, 5'b00010}) begin
      fails++; $display("FAIL len0_trace got sig=%b busy=%b und=%b expected 00000/11100/00010",
                        sig_tr, busy_tr, und_tr);
    end
  endtask

  task automatic test_full_fifo();
    logic ro, re, ac;
    logic [CNT_W+2:0] got, want;
    int e0 = 0, acc5 = -1, sent = 0, step = 0;
    // step 0: long run, steps 1-2: idle, then five held-valid pushes, then drain
    while (step < 3 || (sent < 5 && step < 250) || (sent == 5 && step < acc5 - e0 + 12)) begin
      if (step == 0)     drive(1'b1, 1'b1, 100, 1'b1, ro, re, ac);
      else if (step < 3) drive(1'b0, 1'b0, 0, 1'b1, ro, re, ac);
      else               drive(sent < 5, sent[0], 1, 1'b1, ro, re, ac);
      if (step == 0) e0 = cyc;
      tests++;
      if (ro !== re) begin
        fails++; $display("FAIL full_ready cyc=%0d got %b expected %b", cyc, ro, re);
      end
      got  = {signal_out, busy_out, underrun_out, fifo_count_out};
      want = {exp_sig(cyc), exp_busy(cyc), exp_under(cyc), CNT_W'(model_count(cyc))};
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL full_outputs cyc=%0d {sig,busy,und,cnt} got %b expected %b", cyc, got, want);
      end
      if (step >= 3 && ac) begin
        sent++;
        if (sent == 4) begin
          tests++;
          if (fifo_count_out !== CNT_W'(4) || cmd_ready_out !== 1'b0) begin
            fails++; $display("FAIL full_at_depth cnt=%0d ready=%b expected cnt=4 ready=0",
                              fifo_count_out, cmd_ready_out);
          end
        end
        if (sent == 5) acc5 = cyc;
      end
      step++;
    end
    tests++;
    if (acc5 != e0 + 102) begin
      fails++; $display("FAIL full_fifth_accept edge got %0d expected %0d", acc5 - e0, 102);
    end
  endtask

  task automatic test_reset_mid_run();
    logic ro, re, ac;
    logic [CNT_W+2:0] got, want;
    int und_seen = 0, e1 = 0;
    for (int i = 0; i < 80; i++) begin
      if (i == 0)       drive(1'b1, 1'b1, 50, 1'b1, ro, re, ac);
      else if (i < 3)   drive(1'b1, i[0], 2, 1'b1, ro, re, ac);
      else if (i == 10) drive(1'b0, 1'b0, 0, 1'b0, ro, re, ac);
      else if (i == 70) drive(1'b1, 1'b1, 2, 1'b1, ro, re, ac);
      else              drive(1'b0, 1'b0, 0, 1'b1, ro, re, ac);
      tests++;
      if (ro !== re) begin
        fails++; $display("FAIL rstmid_ready cyc=%0d got %b expected %b", cyc, ro, re);
      end
      got  = {signal_out, busy_out, underrun_out, fifo_count_out};
      want = {exp_sig(cyc), exp_busy(cyc), exp_under(cyc), CNT_W'(model_count(cyc))};
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL rstmid_outputs cyc=%0d {sig,busy,und,cnt} got %b expected %b", cyc, got, want);
      end
      if (i == 10) begin
        tests++;
        if (got !== '0) begin
          fails++; $display("FAIL rstmid_cleared got %b expected all zero", got);
        end
      end
      if (i > 10 && i < 70 && underrun_out) und_seen++;
      if (i == 70) e1 = cyc;
      if (i == 71) begin
        tests++;
        if (cyc != e1 + 1 || signal_out !== 1'b1 || busy_out !== 1'b1) begin
          fails++; $display("FAIL rstmid_first_latency sig=%b busy=%b expected 1/1", signal_out, busy_out);
        end
      end
    end
    tests++;
    if (und_seen != 0) begin
      fails++; $display("FAIL rstmid_no_underrun got %0d pulses expected 0", und_seen);
    end
  endtask

  task automatic test_wrap();
    logic ro, re, ac;
    logic [CNT_W+2:0] got, want;
    int sent = 0, busy_cycles = 0, und_seen = 0, max_cnt = 0;
    for (int i = 0; i < 90; i++) begin
      drive(sent < 10, sent[0], sent + 1, 1'b1, ro, re, ac);
      if (ac) sent++;
      tests++;
      if (ro !== re) begin
        fails++; $display("FAIL wrap_ready cyc=%0d got %b expected %b", cyc, ro, re);
      end
      got  = {signal_out, busy_out, underrun_out, fifo_count_out};
      want = {exp_sig(cyc), exp_busy(cyc), exp_under(cyc), CNT_W'(model_count(cyc))};
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL wrap_outputs cyc=%0d {sig,busy,und,cnt} got %b expected %b", cyc, got, want);
      end
      if (busy_out === 1'b1) busy_cycles++;
      if (underrun_out === 1'b1) und_seen++;
      if (int'(fifo_count_out) > max_cnt) max_cnt = int'(fifo_count_out);
    end
    tests++;
    if (sent != 10 || busy_cycles != 55 || und_seen != 1 || max_cnt > DEPTH) begin
      fails++; $display("FAIL wrap_totals sent=%0d busy=%0d und=%0d maxcnt=%0d expected 10/55/1/<=4",
                        sent, busy_cycles, und_seen, max_cnt);
    end
  endtask

  task automatic test_max_len();
    logic ro, re, ac;
    logic [CNT_W+2:0] got, want;
    int busy_cycles = 0, high_cycles = 0, und_seen = 0;
    for (int i = 0; i < 262; i++) begin
      drive(i == 0, 1'b1, (1 << LEN_W) - 1, 1'b1, ro, re, ac);
      tests++;
      if (ro !== re) begin
        fails++; $display("FAIL maxlen_ready cyc=%0d got %b expected %b", cyc, ro, re);
      end
      got  = {signal_out, busy_out, underrun_out, fifo_count_out};
      want = {exp_sig(cyc), exp_busy(cyc), exp_under(cyc), CNT_W'(model_count(cyc))};
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL maxlen_outputs cyc=%0d {sig,busy,und,cnt} got %b expected %b", cyc, got, want);
      end
      if (busy_out === 1'b1) busy_cycles++;
      if (busy_out === 1'b1 && signal_out === 1'b1) high_cycles++;
      if (underrun_out === 1'b1) und_seen++;
    end
    tests++;
    if (busy_cycles != 255 || high_cycles != 255 || und_seen != 1) begin
      fails++; $display("FAIL maxlen_totals busy=%0d high=%0d und=%0d expected 255/255/1",
                        busy_cycles, high_cycles, und_seen);
    end
  endtask

  task automatic test_random();
    logic ro, re, ac;
    logic [CNT_W+2:0] got, want;
    logic v, lv, rv;
    int   ln;
    for (int i = 0; i < 440; i++) begin
      v  = (i < 400) && ($urandom_range(0, 1) == 1);
      lv = logic'($urandom_range(0, 1));
      ln = int'($urandom_range(0, 5));
      rv = (i >= 400) || ($urandom_range(0, 63) != 0);
      drive(v, lv, ln, rv, ro, re, ac);
      tests++;
      if (ro !== re) begin
        fails++; $display("FAIL random_ready cyc=%0d got %b expected %b", cyc, ro, re);
      end
      got  = {signal_out, busy_out, underrun_out, fifo_count_out};
      want = {exp_sig(cyc), exp_busy(cyc), exp_under(cyc), CNT_W'(model_count(cyc))};
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL random_outputs cyc=%0d {sig,busy,und,cnt} got %b expected %b", cyc, got, want);
      end
    end
  endtask

  initial begin
    rst_in       = 1'b0;
    cmd_valid_in = 1'b0;
    cmd_level_in = 1'b0;
    cmd_len_in   = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_len0_merge();
    test_full_fifo();
    test_reset_mid_run();
    test_wrap();
    test_max_len();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
